alu_op_sequencer: RTL and testbench

Sequential initiator for the combinational 8-bit ALU. It accepts operation commands over a valid/ready handshake and drives the ALU's OpCode/InputA/InputB ports. It holds them for a programmable settle time, captures OutALU/COut into registers, and returns them over a second valid/ready handshake. A sweep mode issues all eight opcodes in order for one operand pair, replacing hand-written stimulus sequences in system-level use.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_op_sequencer.sv | 145 ++++++++++++++
 tb/tb_alu_op_sequencer.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU and the sequencer that drives it:
// opcode encodings, default widths and sequencer state encoding.
package alu_pkg;

  localparam int DATA_W = 8;
  localparam int OP_W   = 3;
  localparam int RES_W  = 2 * DATA_W;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_MUL = 3'b010;
  localparam logic [2:0] ALU_SHL = 3'b011;
  localparam logic [2:0] ALU_SHR = 3'b100;
  localparam logic [2:0] ALU_AND = 3'b101;
  localparam logic [2:0] ALU_OR  = 3'b110;
  localparam logic [2:0] ALU_XOR = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
  } seq_state_e;

endpackage

// File: rtl/alu_op_sequencer.sv
// Drives a combinational ALU from a command handshake, waits a fixed settle
// time, captures its result and hands it back on a response handshake.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W        = alu_pkg::DATA_W,
  parameter int OP_W          = alu_pkg::OP_W,
  parameter int RES_W         = alu_pkg::RES_W,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              CmdValid,
  output logic              CmdReady,
  input  logic [OP_W-1:0]   CmdOpCode,
  input  logic [DATA_W-1:0] CmdA,
  input  logic [DATA_W-1:0] CmdB,
  input  logic              CmdSweep,
  output logic              RspValid,
  input  logic              RspReady,
  output logic [OP_W-1:0]   RspOpCode,
  output logic [RES_W-1:0]  RspOut,
  output logic              RspCOut,
  output logic              RspLast,
  output logic              Busy,
  output logic [OP_W-1:0]   OpCode,
  output logic [DATA_W-1:0] InputA,
  output logic [DATA_W-1:0] InputB,
  input  logic [RES_W-1:0]  OutALU,
  input  logic              COut
);

  localparam logic [3:0]      SETTLE_LD = 4'(SETTLE_CYCLES);
  localparam logic [OP_W-1:0] OP_FIRST  = '0;
  localparam logic [OP_W-1:0] OP_LAST   = '1;
  localparam logic [OP_W-1:0] OP_ONE    = OP_W'(1);

  seq_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              sweep_q, sweep_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [OP_W-1:0]   rsp_op_q, rsp_op_d;
  logic [RES_W-1:0]  rsp_out_q, rsp_out_d;
  logic              rsp_cout_q, rsp_cout_d;
  logic              rsp_last_q, rsp_last_d;

  // Gated by rst so nothing is offered during the reset cycle itself.
  assign CmdReady = (state_q == ST_IDLE) && !rst;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sweep_d     = sweep_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_op_d    = rsp_op_q;
    rsp_out_d   = rsp_out_q;
    rsp_cout_d  = rsp_cout_q;
    rsp_last_d  = rsp_last_q;

    case (state_q)
      ST_IDLE: begin
        if (CmdValid && CmdReady) begin
          a_d     = CmdA;
          b_d     = CmdB;
          op_d    = CmdSweep ? OP_FIRST : CmdOpCode;
          sweep_d = CmdSweep;
          cnt_d   = SETTLE_LD;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        // <=1 also covers an out-of-range zero load instead of wrapping.
        if (cnt_q <= 4'd1) begin
          rsp_out_d   = OutALU;
          rsp_cout_d  = COut;
          rsp_op_d    = op_q;
          rsp_last_d  = !sweep_q || (op_q == OP_LAST);
          rsp_valid_d = 1'b1;
          cnt_d       = 4'd0;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (RspReady) begin
          rsp_valid_d = 1'b0;
          if (sweep_q && (op_q != OP_LAST)) begin
            op_d    = op_q + OP_ONE;
            cnt_d   = SETTLE_LD;
            state_d = ST_SETTLE;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      sweep_q     <= 1'b0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_op_q    <= '0;
      rsp_out_q   <= '0;
      rsp_cout_q  <= 1'b0;
      rsp_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sweep_q     <= sweep_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_op_q    <= rsp_op_d;
      rsp_out_q   <= rsp_out_d;
      rsp_cout_q  <= rsp_cout_d;
      rsp_last_q  <= rsp_last_d;
    end
  end

  assign Busy      = (state_q != ST_IDLE);
  assign OpCode    = op_q;
  assign InputA    = a_q;
  assign InputB    = b_q;
  assign RspValid  = rsp_valid_q;
  assign RspOpCode = rsp_op_q;
  assign RspOut    = rsp_out_q;
  assign RspCOut   = rsp_cout_q;
  assign RspLast   = rsp_last_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a behavioural ALU beside it;
// a second instance runs with a 3-cycle settle time.
module tb_alu_op_sequencer;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        CmdValid, CmdReady, CmdSweep, RspValid, RspReady, RspCOut, RspLast, Busy, COut;
  logic [2:0]  CmdOpCode, RspOpCode, OpCode;
  logic [7:0]  CmdA, CmdB, InputA, InputB;
  logic [15:0] RspOut, OutALU;

  logic        CmdValid3, CmdReady3, RspValid3, RspReady3, RspCOut3, RspLast3, Busy3, COut3;
  logic [2:0]  RspOpCode3, OpCode3;
  logic [7:0]  InputA3, InputB3;
  logic [15:0] RspOut3, OutALU3;

  alu_op_sequencer #(.SETTLE_CYCLES(1)) u_dut (
    .clk(clk), .rst(rst), .CmdValid(CmdValid), .CmdReady(CmdReady), .CmdOpCode(CmdOpCode),
    .CmdA(CmdA), .CmdB(CmdB), .CmdSweep(CmdSweep), .RspValid(RspValid), .RspReady(RspReady),
    .RspOpCode(RspOpCode), .RspOut(RspOut), .RspCOut(RspCOut), .RspLast(RspLast), .Busy(Busy),
    .OpCode(OpCode), .InputA(InputA), .InputB(InputB), .OutALU(OutALU), .COut(COut)
  );

  alu_op_sequencer #(.SETTLE_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst), .CmdValid(CmdValid3), .CmdReady(CmdReady3), .CmdOpCode(CmdOpCode),
    .CmdA(CmdA), .CmdB(CmdB), .CmdSweep(1'b0), .RspValid(RspValid3), .RspReady(RspReady3),
    .RspOpCode(RspOpCode3), .RspOut(RspOut3), .RspCOut(RspCOut3), .RspLast(RspLast3), .Busy(Busy3),
    .OpCode(OpCode3), .InputA(InputA3), .InputB(InputB3), .OutALU(OutALU3), .COut(COut3)
  );

  // Behavioural ALU: carry out of ADD, borrow out of SUB, single-bit shifts.
  function automatic logic [16:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] r;
    logic        c;
    r = '0;
    c = 1'b0;
    case (op)
      ALU_ADD: begin r = {8'd0, a} + {8'd0, b}; c = r[8]; end
      ALU_SUB: begin r = {8'd0, a} - {8'd0, b}; c = (a < b); end
      ALU_MUL: r = {8'd0, a} * {8'd0, b};
      ALU_SHL: r = {8'd0, a} << 1;
      ALU_SHR: r = {8'd0, a >> 1};
      ALU_AND: r = {8'd0, a & b};
      ALU_OR:  r = {8'd0, a | b};
      default: r = {8'd0, a ^ b};
    endcase
    return {c, r};
  endfunction

  always_comb {COut, OutALU}   = alu_f(OpCode, InputA, InputB);
  always_comb {COut3, OutALU3} = alu_f(OpCode3, InputA3, InputB3);

  typedef struct packed {
    logic [2:0]  op;
    logic [15:0] out;
    logic        cout;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   rsp_cnt  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [2:0] op, input logic [15:0] out, input logic cout, input logic last);
    exp_q.push_back('{op: op, out: out, cout: cout, last: last});
  endtask

  // Monitor: every completed response handshake is matched against the queue.
  always @(negedge clk) begin
    if (RspValid && RspReady) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", {29'd0, RspOpCode}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_opcode", {29'd0, RspOpCode}, {29'd0, e.op});
        chk("rsp_out",    {16'd0, RspOut},    {16'd0, e.out});
        chk("rsp_cout",   {31'd0, RspCOut},   {31'd0, e.cout});
        chk("rsp_last",   {31'd0, RspLast},   {31'd0, e.last});
      end
      rsp_cnt++;
    end
  end

  // Returns #1 after the accept edge.
  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic sw);
    int n = 0;
    CmdValid = 1'b1; CmdOpCode = op; CmdA = a; CmdB = b; CmdSweep = sw;
    while (!CmdReady && n < 50) begin @(posedge clk); #1; n++; end
    chk("send_timeout", {31'd0, n < 50}, 32'd1);
    @(posedge clk); #1;
    CmdValid = 1'b0;
  endtask

  task automatic wait_rsp(input int target);
    int n = 0;
    while (rsp_cnt < target && n < 200) begin @(posedge clk); #1; n++; end
    chk("rsp_timeout", {31'd0, rsp_cnt >= target}, 32'd1);
  endtask

  initial begin
    int  n;
    logic bad;
    CmdValid = 0; CmdOpCode = 0; CmdA = 0; CmdB = 0; CmdSweep = 0; RspReady = 1;
    CmdValid3 = 0; RspReady3 = 1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmdready", {31'd0, CmdReady}, 0);
    chk("rst_rspvalid", {31'd0, RspValid}, 0);
    chk("rst_busy",     {31'd0, Busy}, 0);
    chk("rst_ports",    {8'd0, OpCode, 5'd0, InputA, InputB}, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_cmdready", {31'd0, CmdReady}, 1);

    // Single ADD with timing.
    push(ALU_ADD, 16'd83, 1'b0, 1'b1);
    send(ALU_ADD, 8'd45, 8'd38, 1'b0);
    chk("add_busy",       {31'd0, Busy}, 1);
    chk("add_cmdready_0", {31'd0, CmdReady}, 0);
    chk("add_ports",      {13'd0, OpCode, InputA, InputB}, {13'd0, 3'd0, 8'd45, 8'd38});
    @(posedge clk); #1;
    chk("add_latency",    {31'd0, RspValid}, 1);
    @(posedge clk); #1;
    chk("add_cmdready_1", {31'd0, CmdReady}, 1);
    chk("add_rsp_drop",   {31'd0, RspValid}, 0);

    push(ALU_SUB, 16'd7, 1'b0, 1'b1);  send(ALU_SUB, 8'd45, 8'd38, 1'b0); wait_rsp(2);
    push(ALU_OR,  16'd47, 1'b0, 1'b1); send(ALU_OR,  8'd45, 8'd38, 1'b0); wait_rsp(3);
    push(ALU_XOR, 16'd11, 1'b0, 1'b1); send(ALU_XOR, 8'd45, 8'd38, 1'b0); wait_rsp(4);

    // Sweep 49,10: opcode input is ignored.
    push(3'd0, 16'd59,  1'b0, 1'b0);
    push(3'd1, 16'd39,  1'b0, 1'b0);
    push(3'd2, 16'd490, 1'b0, 1'b0);
    push(3'd3, 16'd98,  1'b0, 1'b0);
    push(3'd4, 16'd24,  1'b0, 1'b0);
    push(3'd5, 16'd0,   1'b0, 1'b0);
    push(3'd6, 16'd59,  1'b0, 1'b0);
    push(3'd7, 16'd59,  1'b0, 1'b1);
    send(ALU_AND, 8'd49, 8'd10, 1'b1);
    n = 0; bad = 1'b0;
    while (rsp_cnt < 12 && n < 100) begin
      if (CmdReady) bad = 1'b1;
      @(posedge clk); #1; n++;
    end
    chk("sweep_cmdready_low", {31'd0, bad}, 0);
    chk("sweep_count",        rsp_cnt, 12);
    chk("sweep_cycles",       n, 16);
    chk("sweep_idle",         {31'd0, Busy}, 0);

    // Backpressure on MUL, with an ignored command pulse.
    RspReady = 1'b0;
    push(ALU_MUL, 16'd490, 1'b0, 1'b1);
    send(ALU_MUL, 8'd49, 8'd10, 1'b0);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'd0, RspValid}, 1);
      chk("bp_out",   {16'd0, RspOut}, 490);
      chk("bp_op",    {29'd0, RspOpCode}, 2);
      if (i == 1) begin
        CmdValid = 1'b1; CmdOpCode = ALU_ADD; CmdA = 8'd7; CmdB = 8'd9; CmdSweep = 1'b0;
      end
      @(posedge clk); #1;
      CmdValid = 1'b0;
    end
    chk("bp_inputa", {24'd0, InputA}, 49);
    chk("bp_inputb", {24'd0, InputB}, 10);
    RspReady = 1'b1;
    wait_rsp(13);
    repeat (4) @(posedge clk);
    #1;
    chk("bp_not_queued", {31'd0, Busy}, 0);

    // SETTLE_CYCLES=3 instance: ADD 255+1.
    CmdOpCode = ALU_ADD; CmdA = 8'd255; CmdB = 8'd1; CmdValid3 = 1'b1;
    @(posedge clk); #1;
    CmdValid3 = 1'b0; CmdA = 8'd0; CmdB = 8'd0;
    for (int k = 0; k < 3; k++) begin
      chk("s3_wait",  {31'd0, RspValid3}, 0);
      chk("s3_ports", {16'd0, InputA3, InputB3}, {16'd0, 8'd255, 8'd1});
      @(posedge clk); #1;
    end
    chk("s3_valid", {31'd0, RspValid3}, 1);
    chk("s3_out",   {16'd0, RspOut3}, 256);
    chk("s3_cout",  {31'd0, RspCOut3}, 1);
    chk("s3_last",  {29'd0, RspOpCode3, RspLast3}, 1);
    @(posedge clk); #1;
    chk("s3_idle",  {30'd0, CmdReady3, RspValid3}, 2);

    // Reset after the third sweep response.
    push(3'd0, 16'd59,  1'b0, 1'b0);
    push(3'd1, 16'd39,  1'b0, 1'b0);
    push(3'd2, 16'd490, 1'b0, 1'b0);
    send(ALU_ADD, 8'd49, 8'd10, 1'b1);
    wait_rsp(16);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_valid",    {31'd0, RspValid}, 0);
    chk("mid_rst_busy",     {31'd0, Busy}, 0);
    chk("mid_rst_cmdready", {31'd0, CmdReady}, 0);
    chk("mid_rst_ports",    {8'd0, OpCode, 5'd0, InputA, InputB}, 0);
    chk("mid_rst_rsp",      {11'd0, RspOpCode, RspOut, RspCOut, RspLast}, 0);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("mid_rst_no_more", rsp_cnt, 16);

    push(ALU_ADD, 16'd3, 1'b0, 1'b1);
    send(ALU_ADD, 8'd1, 8'd2, 1'b0);
    wait_rsp(17);
    chk("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
